// File: rtl/gen_ram_dp.sv
// gen_ram_dp: simple dual-port RAM (one write port, one read port).
//   - Per-byte-lane write enables; the top lane may be narrower than 8 bits.
//   - Read latency of 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), fully pipelined.
//   - Optional write-first bypass when read and write hit the same word.
//   - Optional post-reset sequencer that fills every word with INIT_VAL.
//   - Addresses at or above DP drop writes and read back as zero.
// Ports:
//   clk      in  1   clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   we_i     in  1   write request (qualified by ready_o)
//   waddr_i  in  AW  write word address
//   wdata_i  in  DW  write data
//   wsel_i   in  MW  per-lane write enable
//   re_i     in  1   read request (qualified by ready_o)
//   raddr_i  in  AW  read word address
//   rdata_o  out DW  read data, held until the next read returns
//   rvalid_o out 1   one-cycle pulse when rdata_o is updated
//   ready_o  out 1   RAM accepts traffic (low while initialising)
module gen_ram_dp #(
  parameter int unsigned    DP       = 512,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    MW       = 4,
  parameter int unsigned    AW       = 9,
  parameter bit             OUT_REG  = 1'b0,
  parameter bit             BYPASS   = 1'b1,
  parameter bit             INIT_EN  = 1'b1,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [MW-1:0] wsel_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o,
  output logic          ready_o
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW:0]   DP_W      = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DP-1);

  // Bits selected by mask come from new, the rest keep old.
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [DW-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [DW-1:0]  mem_q [DP];

  logic [0:0]     state_q, state_d;
  logic [AW-1:0]  init_cnt_q, init_cnt_d;

  logic [DW-1:0]  lane_mask;
  logic           wr_in_range, rd_in_range;
  logic           wr_acc, rd_acc;

  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_wmask;

  logic [DW-1:0]  rd_old, rd_word;

  logic [DW-1:0]  rdata_p1_q;
  logic           vld_p1_q;

  assign ready_o = (state_q == ST_RUN);

  // Expand lane enables to a bit mask; bit b belongs to lane b/8, which also
  // makes a partial top lane fall out naturally.
  for (genvar b = 0; b < DW; b++) begin : g_mask
    assign lane_mask[b] = wsel_i[b/8];
  end

  assign wr_in_range = ({1'b0, waddr_i} < DP_W);
  assign rd_in_range = ({1'b0, raddr_i} < DP_W);
  assign wr_acc      = ready_o & we_i & wr_in_range;
  assign rd_acc      = ready_o & re_i;

  // Init sequencer: one full word per cycle, leaves INIT after writing DP-1.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
      else                         init_cnt_d = init_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Array write port is shared between the init sequencer and user writes.
  always_comb begin
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = INIT_VAL;
      mem_wmask = '1;
    end else begin
      mem_we    = wr_acc;
      mem_waddr = waddr_i;
      mem_wdata = wdata_i;
      mem_wmask = lane_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= merge_lanes(mem_q[mem_waddr], mem_wdata, mem_wmask);
  end

  // Read word as seen this cycle; write-first merge applies only to lanes
  // being written to the same address.
  assign rd_old = rd_in_range ? mem_q[raddr_i] : '0;

  always_comb begin
    rd_word = rd_old;
    if (BYPASS && wr_acc && (waddr_i == raddr_i)) begin
      rd_word = merge_lanes(rd_old, wdata_i, lane_mask);
    end
  end

  // ---- stage p1: array read register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      vld_p1_q <= rd_acc;
      if (rd_acc) rdata_p1_q <= rd_word;
    end
  end

  // ---- stage p2: optional output register ----
  if (OUT_REG) begin : g_oreg
    logic [DW-1:0] rdata_p2_q;
    logic          vld_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q   <= 1'b0;
        rdata_p2_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) rdata_p2_q <= rdata_p1_q;
      end
    end

    assign rdata_o  = rdata_p2_q;
    assign rvalid_o = vld_p2_q;
  end else begin : g_noreg
    assign rdata_o  = rdata_p1_q;
    assign rvalid_o = vld_p1_q;
  end

endmodule

// File: tb/tb_gen_ram_dp.sv
// Testbench for gen_ram_dp: two instances run side by side.
//   A: DP=16, DW=32, OUT_REG=0, BYPASS=1, INIT_VAL=32'hA5A5A5A5
//   B: DP=12, DW=20, MW=3, OUT_REG=1, BYPASS=0, INIT_VAL=0
module tb_gen_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;

  logic        a_we = 1'b0, a_re = 1'b0;
  logic [3:0]  a_waddr = '0, a_raddr = '0, a_wsel = '0;
  logic [31:0] a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_rvalid, a_ready;

  logic        b_we = 1'b0, b_re = 1'b0;
  logic [3:0]  b_waddr = '0, b_raddr = '0;
  logic [2:0]  b_wsel = '0;
  logic [19:0] b_wdata = '0;
  logic [19:0] b_rdata;
  logic        b_rvalid, b_ready;

  gen_ram_dp #(.DP(16), .DW(32), .MW(4), .AW(4), .OUT_REG(1'b0), .BYPASS(1'b1),
               .INIT_EN(1'b1), .INIT_VAL(32'hA5A5A5A5)) u_a (
    .clk(clk), .rst_n(rst_n), .we_i(a_we), .waddr_i(a_waddr), .wdata_i(a_wdata),
    .wsel_i(a_wsel), .re_i(a_re), .raddr_i(a_raddr), .rdata_o(a_rdata),
    .rvalid_o(a_rvalid), .ready_o(a_ready));

  gen_ram_dp #(.DP(12), .DW(20), .MW(3), .AW(4), .OUT_REG(1'b1), .BYPASS(1'b0),
               .INIT_EN(1'b1), .INIT_VAL(20'h00000)) u_b (
    .clk(clk), .rst_n(rst_n), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .wsel_i(b_wsel), .re_i(b_re), .raddr_i(b_raddr), .rdata_o(b_rdata),
    .rvalid_o(b_rvalid), .ready_o(b_ready));

  // Per-instance configuration seen by the reference model.
  localparam int          DPK   [2] = '{16, 12};
  localparam int          MWK   [2] = '{4, 3};
  localparam int          LAT   [2] = '{1, 2};
  localparam bit          BYP   [2] = '{1'b1, 1'b0};
  localparam logic [31:0] DWM   [2] = '{32'hFFFFFFFF, 32'h000FFFFF};
  localparam logic [31:0] INITV [2] = '{32'hA5A5A5A5, 32'h00000000};

  typedef struct packed {
    int          due;
    logic [31:0] d;
  } pend_t;

  logic [31:0] mdl [2][16];
  logic [31:0] held [2];
  int          init_left [2];
  pend_t       q0[$];
  pend_t       q1[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cycle    = 0;

  function automatic logic [31:0] rd(input int k);
    return (k == 0) ? a_rdata : {12'h000, b_rdata};
  endfunction

  function automatic logic [31:0] rv(input int k);
    return (k == 0) ? {31'd0, a_rvalid} : {31'd0, b_rvalid};
  endfunction

  function automatic logic [31:0] rdy(input int k);
    return (k == 0) ? {31'd0, a_ready} : {31'd0, b_ready};
  endfunction

  function automatic logic [31:0] lane_bits(input int k, input logic [3:0] ws);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < MWK[k]; i++) if (ws[i]) m = m | (32'hFF << (8*i));
    return m & DWM[k];
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] cycle %0d observed=%h expected=%h", tag, k, cycle, got, exp);
    end
  endtask

  // Drive one request on instance k for the coming edge and update the model.
  task automatic req(input int k, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input logic r, input logic [3:0] ra);
    logic [31:0] m, res;
    pend_t p;
    if (k == 0) begin
      a_we = w; a_waddr = wa; a_wdata = wd; a_wsel = ws; a_re = r; a_raddr = ra;
    end else begin
      b_we = w; b_waddr = wa; b_wdata = wd[19:0]; b_wsel = ws[2:0]; b_re = r; b_raddr = ra;
    end
    if (init_left[k] != 0) return;
    m = lane_bits(k, ws);
    if (r) begin
      if (ra >= DPK[k]) res = '0;
      else begin
        res = mdl[k][ra];
        if (BYP[k] && w && (wa == ra)) res = (res & ~m) | (wd & m);
      end
      p.due = cycle + LAT[k];
      p.d   = res;
      if (k == 0) q0.push_back(p); else q1.push_back(p);
    end
    if (w && (wa < DPK[k])) mdl[k][wa] = (mdl[k][wa] & ~m) | (wd & m);
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; a_re = 1'b0; a_wsel = '0;
    b_we = 1'b0; b_re = 1'b0; b_wsel = '0;
  endtask

  // Advance one clock and check ready/rvalid/rdata of both instances.
  task automatic cyc();
    pend_t p;
    logic  ev;
    @(posedge clk);
    cycle++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst_n && init_left[k] > 0) init_left[k]--;
      ev = 1'b0;
      if (k == 0) begin
        if (q0.size() > 0 && q0[0].due == cycle) begin p = q0.pop_front(); ev = 1'b1; held[0] = p.d; end
      end else begin
        if (q1.size() > 0 && q1[0].due == cycle) begin p = q1.pop_front(); ev = 1'b1; held[1] = p.d; end
      end
      chk("ready", k, rdy(k), {31'd0, init_left[k] == 0});
      chk("rvalid", k, rv(k), {31'd0, ev});
      chk("rdata", k, rd(k), held[k]);
    end
    idle_inputs();
  endtask

  // Assert reset between edges, check outputs clear at once, release mid-cycle.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdata", k, rd(k), 32'h0);
      chk("rst_rvalid", k, rv(k), 32'h0);
      chk("rst_ready", k, rdy(k), 32'h0);
      held[k] = '0;
      init_left[k] = DPK[k];
      for (int i = 0; i < 16; i++) mdl[k][i] = INITV[k] & DWM[k];
    end
    q0.delete();
    q1.delete();
    idle_inputs();
    @(posedge clk); cycle++;
    @(posedge clk); cycle++;
    #1 rst_n = 1'b1;
  endtask

  task automatic rnd_req();
    logic [3:0] wa, ra;
    for (int k = 0; k < 2; k++) begin
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = wa;
      req(k, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ra);
    end
  endtask

  initial begin
    // Init fill: ready low for DP cycles, then every word reads INIT_VAL.
    do_reset();
    repeat (16) cyc();
    for (int i = 0; i < 16; i++) begin
      req(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i));
      if (i < 12) req(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i));
      cyc();
    end
    repeat (3) cyc();
    chk("init_word", 0, rd(0), 32'hA5A5A5A5);

    // Byte-lane writes.
    for (int k = 0; k < 2; k++) req(k, 1'b1, 4'd3, 32'h11223344, 4'b1111, 1'b0, 4'd0);
    cyc();
    for (int k = 0; k < 2; k++) req(k, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0);
    cyc();
    for (int k = 0; k < 2; k++) req(k, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
    cyc();
    repeat (3) cyc();
    chk("lanes", 0, rd(0), 32'h11BB33DD);
    chk("lanes", 1, rd(1), 32'h000B33DD);

    // Same-cycle read/write to one address: write-first on A, read-first on B.
    for (int k = 0; k < 2; k++) req(k, 1'b1, 4'd5, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd5);
    cyc();
    repeat (3) cyc();
    chk("bypass", 0, rd(0), 32'hA5A5BEEF);
    chk("bypass", 1, rd(1), 32'h00000000);
    for (int k = 0; k < 2; k++) req(k, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
    cyc();
    repeat (3) cyc();
    chk("after_rw", 0, rd(0), 32'hA5A5BEEF);
    chk("after_rw", 1, rd(1), 32'h0000BEEF);

    // Out-of-range address and partial top lane on B.
    req(1, 1'b1, 4'd13, 32'h000FFFFF, 4'b0111, 1'b0, 4'd0);
    cyc();
    req(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd13);
    cyc();
    repeat (3) cyc();
    chk("oor_read", 1, rd(1), 32'h0);
    req(1, 1'b1, 4'd2, 32'h000FFFFF, 4'b0100, 1'b0, 4'd0);
    cyc();
    req(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
    cyc();
    repeat (3) cyc();
    chk("top_lane", 1, rd(1), 32'h000F0000);

    // Streaming reads on consecutive cycles, then hold.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) req(k, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i));
      cyc();
    end
    repeat (4) cyc();
    chk("stream_hold", 0, rd(0), mdl[0][7]);
    chk("stream_hold", 1, rd(1), mdl[1][7]);

    // Reset mid-init, traffic during init is ignored, then reset mid-read.
    do_reset();
    repeat (5) begin rnd_req(); cyc(); end
    do_reset();
    repeat (16) begin rnd_req(); cyc(); end
    for (int k = 0; k < 2; k++) req(k, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
    cyc();
    do_reset();
    repeat (18) cyc();

    // Random traffic against the model.
    repeat (400) begin rnd_req(); cyc(); end
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
